// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   state_t       : converter FSM states (IDLE, SHIFT, DONE)
//   BCD_DIGIT_W   : bits per BCD digit
//   ADD3_THRESH   : digit value at or above which +3 is applied before a shift
//   digits_enough : true when DIGITS decimal digits can hold 2^WIDTH-1
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] ADD3_THRESH = 4'd5;

  // Compares 10^digits against the largest WIDTH-bit value. The decimal
  // capacity saturates so that large DIGITS values cannot overflow.
  function automatic bit digits_enough(input int width, input int digits);
    longint unsigned cap;
    longint unsigned maxv;
    cap = 64'd1;
    for (int i = 0; i < digits; i++) begin
      if (cap <= 64'd1_000_000_000_000_000_000)
        cap = cap * 64'd10;
    end
    if (width >= 64)
      maxv = {64{1'b1}};
    else
      maxv = (64'd1 << width) - 64'd1;
    return cap > maxv;
  endfunction

endpackage

// File: rtl/dabble_digit.sv
// Per-digit double-dabble correction: a digit that is 5 or more gets 3 added
// so that the following left shift carries correctly into the next decade.
// Ports:
//   din  : current 4-bit BCD digit (0..9 in normal operation)
//   dout : corrected digit, ready to be shifted
module dabble_digit
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  always_comb begin
    dout = din;
    if (din >= ADD3_THRESH)
      dout = din + BCD_DIGIT_W'(3);
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 (double-dabble) binary to packed BCD converter.
// One bit of the input is consumed per SHIFT cycle; the result is published
// in DONE together with a one-cycle valid pulse.
// Parameters:
//   WIDTH  : binary input width
//   DIGITS : number of BCD output digits (10^DIGITS must exceed 2^WIDTH-1)
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   start : conversion request, honoured only while ready=1
//   bin   : unsigned value, sampled on the accepting edge only
//   ready : high in IDLE
//   busy  : high in SHIFT
//   valid : one-cycle pulse in DONE marking a new bcd value
//   bcd   : packed BCD result, digit 0 (units) in bits [3:0]; held between pulses
//   blank : per-digit leading-zero flag (only with BIN2BCD_BLANK_EN defined);
//           blank[0] is always 0, blank[i] set when digit i and all above are 0
// Optional build macro: BIN2BCD_BLANK_EN enables the blank output.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [WIDTH-1:0]              bin,
  output logic                          ready,
  output logic                          busy,
  output logic                          valid,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd
`ifdef BIN2BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]             blank
`endif
);

  localparam int BW = BCD_DIGIT_W * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  generate
    if (!digits_enough(WIDTH, DIGITS)) begin : g_digits_chk
      $error("bin_to_bcd_seq: DIGITS=%0d cannot represent 2^%0d-1", DIGITS, WIDTH);
    end
    if (WIDTH < 1) begin : g_width_chk
      $error("bin_to_bcd_seq: WIDTH must be at least 1");
    end
  endgenerate

  state_t          state_reg,   state_next;
  logic [WIDTH-1:0] sh_reg,     sh_next;
  logic [BW-1:0]   scratch_reg, scratch_next;
  logic [CW-1:0]   cnt_reg,     cnt_next;
  logic [BW-1:0]   bcd_reg,     bcd_next;

  logic [BW-1:0]         corr;     // scratch after per-digit correction
  logic [BW+WIDTH-1:0]   shifted;  // {corr, sh_reg} shifted left by one
  logic [BW-1:0]         result;   // scratch value after this SHIFT cycle
  logic                  unused_msb;

  // Per-digit correction is applied to the whole scratch register in parallel.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dabble
      dabble_digit u_dabble_digit (
        .din  (scratch_reg[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .dout (corr[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end
  endgenerate

  assign shifted = {corr, sh_reg} << 1;
  assign result  = shifted[BW+WIDTH-1:WIDTH];
  // The corrected top bit is shifted out; with a sufficient DIGITS it is 0.
  assign unused_msb = corr[BW-1];

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_reg, blank_next;
  logic [DIGITS-1:0] hz;          // digit gi and every higher digit are zero
  logic [DIGITS-1:0] blank_load;  // blank flags derived from result

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_blank
      if (gi == DIGITS - 1) begin : g_top
        assign hz[gi] = (result[gi*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
      end else begin : g_chain
        assign hz[gi] = (result[gi*BCD_DIGIT_W +: BCD_DIGIT_W] == '0) && hz[gi+1];
      end
      if (gi == 0) begin : g_units
        // Units digit is always shown so that zero displays as "0".
        assign blank_load[gi] = 1'b0;
      end else begin : g_upper
        assign blank_load[gi] = hz[gi];
      end
    end
  endgenerate

  assign blank = blank_reg;
`endif

  // Next-state, datapath and status outputs.
  always_comb begin
    state_next   = state_reg;
    sh_next      = sh_reg;
    scratch_next = scratch_reg;
    cnt_next     = cnt_reg;
    bcd_next     = bcd_reg;
`ifdef BIN2BCD_BLANK_EN
    blank_next   = blank_reg;
`endif
    ready        = 1'b0;
    busy         = 1'b0;
    valid        = 1'b0;

    case (state_reg)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          sh_next      = bin;
          scratch_next = '0;
          cnt_next     = CW'(WIDTH);
          state_next   = SHIFT;
        end
      end

      SHIFT: begin
        busy         = 1'b1;
        scratch_next = result;
        sh_next      = shifted[WIDTH-1:0];
        cnt_next     = cnt_reg - CW'(1);
        // On the last bit the final scratch value goes straight into the
        // output register, so bcd is already updated during DONE and no
        // intermediate scratch value ever reaches the output.
        if (cnt_reg == CW'(1)) begin
          state_next = DONE;
          bcd_next   = result;
`ifdef BIN2BCD_BLANK_EN
          blank_next = blank_load;
`endif
        end
      end

      DONE: begin
        valid      = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      sh_reg      <= '0;
      scratch_reg <= '0;
      cnt_reg     <= '0;
      bcd_reg     <= '0;
`ifdef BIN2BCD_BLANK_EN
      blank_reg   <= ~DIGITS'(1);
`endif
    end else begin
      state_reg   <= state_next;
      sh_reg      <= sh_next;
      scratch_reg <= scratch_next;
      cnt_reg     <= cnt_next;
      bcd_reg     <= bcd_next;
`ifdef BIN2BCD_BLANK_EN
      blank_reg   <= blank_next;
`endif
    end
  end

  assign bcd = bcd_reg;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq (WIDTH=8, DIGITS=3). The driver pushes
// the expected result when a start is accepted; a monitor pops and compares
// on every valid pulse, also checking latency and digit range.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  bin;
  logic        ready;
  logic        busy;
  logic        valid;
  logic [11:0] bcd;
`ifdef BIN2BCD_BLANK_EN
  logic [2:0]  blank;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [11:0] bcd;
    logic [2:0]  blank;
    int          acc;
    int          bin;
  } exp_t;

  exp_t sbq[$];
  int   vcyc[$];

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .ready (ready),
    .busy  (busy),
    .valid (valid),
    .bcd   (bcd)
`ifdef BIN2BCD_BLANK_EN
    ,
    .blank (blank)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [2:0] ref_blank(input int v);
    return {v < 100, v < 10, 1'b0};
  endfunction

  // Monitor: compares every valid pulse against the scoreboard head.
  initial begin
    exp_t e;
    logic prev_valid;
    logic dig_ok;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (valid) begin
        chk("valid_one_cycle", {31'd0, prev_valid}, 32'd0);
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid actual bcd=%h required=no pulse", bcd);
        end else begin
          e = sbq.pop_front();
          chk($sformatf("bcd(bin=%0d)", e.bin), {20'd0, bcd}, {20'd0, e.bcd});
          chk($sformatf("latency(bin=%0d)", e.bin), cyc - e.acc + 1, 32'd9);
          dig_ok = 1'b1;
          for (int d = 0; d < 3; d++)
            if (bcd[4*d +: 4] > 4'd9) dig_ok = 1'b0;
          chk($sformatf("digits_le_9(bin=%0d)", e.bin), {31'd0, dig_ok}, 32'd1);
`ifdef BIN2BCD_BLANK_EN
          chk($sformatf("blank(bin=%0d)", e.bin), {29'd0, blank}, {29'd0, e.blank});
`endif
          $display("txn bin=%0d bcd=%h latency=%0d", e.bin, bcd, cyc - e.acc + 1);
          vcyc.push_back(cyc);
        end
      end
      prev_valid = valid;
    end
  end

  task automatic wait_ready();
    int k = 0;
    while (!ready && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual ready=0 required=1");
    end
  endtask

  // Issue one accepted start; the expected result is queued at the accepting edge.
  task automatic conv(input int b, input logic [11:0] eb, input logic [2:0] ebl);
    exp_t e;
    wait_ready();
    start = 1'b1;
    bin   = 8'(b);
    @(posedge clk); #1;
    e.bcd = eb; e.blank = ebl; e.acc = cyc; e.bin = b;
    sbq.push_back(e);
    start = 1'b0;
    bin   = ~8'(b);  // bin must not be resampled after acceptance
  endtask

  task automatic drain();
    int k = 0;
    while (sbq.size() != 0 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual pending=%0d required=0", sbq.size());
    end
  endtask

  initial begin
    int n;
    rst   = 1'b1;
    start = 1'b0;
    bin   = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {31'd0, ready}, 32'd1);
    chk("reset_busy",  {31'd0, busy},  32'd0);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_bcd",   {20'd0, bcd},   32'd0);
`ifdef BIN2BCD_BLANK_EN
    chk("reset_blank", {29'd0, blank}, 32'd6);
`endif
    rst = 1'b0;

    // Directed values
    conv(0,   12'h000, 3'b110);
    conv(255, 12'h255, 3'b000);
    conv(99,  12'h099, 3'b100);
    conv(7,   12'h007, 3'b110);
    drain();

    // Start during a conversion is ignored
    conv(128, 12'h128, 3'b000);
    repeat (2) @(posedge clk);
    #1;
    chk("ignored_start_ready", {31'd0, ready}, 32'd0);
    chk("ignored_start_busy",  {31'd0, busy},  32'd1);
    start = 1'b1;
    bin   = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    drain();
    repeat (15) @(posedge clk);
    #1;

    // Reset aborts a conversion in progress
    wait_ready();
    start = 1'b1;
    bin   = 8'd200;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst   = 1'b1;
    start = 1'b1;  // reset wins over start
    @(posedge clk); #1;
    rst   = 1'b0;
    start = 1'b0;
    chk("abort_ready", {31'd0, ready}, 32'd1);
    chk("abort_busy",  {31'd0, busy},  32'd0);
    chk("abort_valid", {31'd0, valid}, 32'd0);
    chk("abort_bcd",   {20'd0, bcd},   32'd0);
    repeat (12) @(posedge clk);
    #1;
    conv(200, 12'h200, 3'b000);
    drain();

    // Back-to-back conversions
    n = vcyc.size();
    conv(42, 12'h042, 3'b100);
    conv(17, 12'h017, 3'b100);
    drain();
    if (vcyc.size() == n + 2)
      chk("b2b_spacing", vcyc[n+1] - vcyc[n], 32'd10);
    else
      chk("b2b_pulses", vcyc.size() - n, 32'd2);

    // Full sweep against a decimal reference
    for (int v = 0; v < 256; v++)
      conv(v, ref_bcd(v), ref_blank(v));
    drain();
    repeat (12) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
